// File: rtl/tag_free_list_pkg.sv
// Shared types and sizing for the physical-tag free list.
// Optional duplicate-free detection is enabled by FREELIST_DOUBLE_FREE_CHECK_EN.
package tag_free_list_pkg;

  localparam int TAG_W      = 6;
  localparam int NUM_PREGS  = 64;
  localparam int NUM_AREGS  = 32;
  localparam int FREE_DEPTH = NUM_PREGS - NUM_AREGS;
  localparam int PTR_W      = 5;
  localparam int CNT_W      = 7;

  typedef logic [TAG_W-1:0] tag_t;
  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam tag_t TAG_ZERO = '0;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } fl_state_e;

endpackage

// File: rtl/tag_ring_buffer.sv
// Circular tag storage with a 2-wide read at head and a 2-wide packed write at tail.
module tag_ring_buffer
  import tag_free_list_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_wr_en_1,
  input  logic [TAG_W-1:0] i_wr_tag_1,
  input  logic             i_wr_en_2,
  input  logic [TAG_W-1:0] i_wr_tag_2,
  input  logic [1:0]       i_head_adv,
  input  logic [1:0]       i_tail_adv,
  output logic [TAG_W-1:0] o_rd_tag_1,
  output logic [TAG_W-1:0] o_rd_tag_2
);

  tag_t r_mem [FREE_DEPTH];
  ptr_t r_head;
  ptr_t r_tail;
  ptr_t w_head_p1;
  ptr_t w_tail_p1;

  // Depth is a power of two, so pointer overflow is the wrap.
  assign w_head_p1  = r_head + ptr_t'(1);
  assign w_tail_p1  = r_tail + ptr_t'(1);
  assign o_rd_tag_1 = r_mem[r_head];
  assign o_rd_tag_2 = r_mem[w_head_p1];

  always_ff @(posedge i_clk) begin
    if (i_wr_en_1) r_mem[r_tail]    <= i_wr_tag_1;
    if (i_wr_en_2) r_mem[w_tail_p1] <= i_wr_tag_2;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      r_head <= r_head + ptr_t'(i_head_adv);
      r_tail <= r_tail + ptr_t'(i_tail_adv);
    end
  end

endmodule

// File: rtl/tag_free_list.sv
// Physical-tag free pool: INIT fill sequencer, 2-wide grant, packed retire push, error checks.
// Define FREELIST_DOUBLE_FREE_CHECK_EN to track pool membership and flag double frees.
module tag_free_list
  import tag_free_list_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       alloc_req_count,
  output logic             alloc_grant,
  output logic [TAG_W-1:0] alloc_tag_1,
  output logic [TAG_W-1:0] alloc_tag_2,
  input  logic [TAG_W-1:0] free_tag_1,
  input  logic [TAG_W-1:0] free_tag_2,
  output logic [CNT_W-1:0] free_count,
  output logic             ready,
  output logic             error,
  output fl_state_e        o_dbg_state
);

  fl_state_e r_state;
  fl_state_e w_state_nxt;
  ptr_t      r_init_ptr;
  cnt_t      r_count;
  logic      r_error;

  logic      w_ready;
  logic      w_req_illegal;
  logic [1:0] w_req;
  logic      w_grant;
  logic [1:0] w_grant_n;
  tag_t      w_rd_tag_1;
  tag_t      w_rd_tag_2;
  tag_t      w_init_tag;
  logic      w_f1_nz;
  logic      w_f2_nz;
  logic      w_f1_ok;
  logic      w_f2_ok;
  logic      w_dup_err;
  logic      w_alloc_err;
  logic [1:0] w_push_n;
  cnt_t      w_cnt_after;
  cnt_t      w_cnt_next;
  logic      w_overflow;
  logic      w_push_en;
  logic      w_err_set;
  logic      w_wr_en_1;
  logic      w_wr_en_2;
  tag_t      w_wr_tag_1;
  tag_t      w_wr_tag_2;
  logic [1:0] w_tail_adv;

  assign w_ready       = reset_n && (r_state == READY);
  assign w_req_illegal = (alloc_req_count == 2'd3);
  assign w_req         = w_req_illegal ? 2'd0 : alloc_req_count;
  assign w_grant       = w_ready && (w_req != 2'd0) && (r_count >= cnt_t'(w_req));
  assign w_grant_n     = w_grant ? w_req : 2'd0;
  assign w_init_tag    = tag_t'(NUM_AREGS) + tag_t'(r_init_ptr);
  assign w_f1_nz       = (free_tag_1 != TAG_ZERO);
  assign w_f2_nz       = (free_tag_2 != TAG_ZERO);

`ifdef FREELIST_DOUBLE_FREE_CHECK_EN
  logic [NUM_PREGS-1:0] r_in_pool;
  logic                 w_dup;

  assign w_dup       = w_f1_nz && w_f2_nz && (free_tag_1 == free_tag_2);
  assign w_f1_ok     = w_f1_nz && !w_dup && !r_in_pool[free_tag_1];
  assign w_f2_ok     = w_f2_nz && !w_dup && !r_in_pool[free_tag_2];
  assign w_dup_err   = (r_state == READY) &&
                       (w_dup || (w_f1_nz && r_in_pool[free_tag_1]) ||
                        (w_f2_nz && r_in_pool[free_tag_2]));
  assign w_alloc_err = w_grant && (!r_in_pool[w_rd_tag_1] ||
                                   ((w_req == 2'd2) && !r_in_pool[w_rd_tag_2]));

  // Grant clears before push sets; a tag granted and freed together is already flagged.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_in_pool <= '0;
    end else if (r_state == INIT) begin
      r_in_pool[w_init_tag] <= 1'b1;
    end else begin
      if (w_grant)                     r_in_pool[w_rd_tag_1] <= 1'b0;
      if (w_grant && (w_req == 2'd2))  r_in_pool[w_rd_tag_2] <= 1'b0;
      if (w_push_en && w_f1_ok)        r_in_pool[free_tag_1] <= 1'b1;
      if (w_push_en && w_f2_ok)        r_in_pool[free_tag_2] <= 1'b1;
    end
  end
`else
  assign w_f1_ok     = w_f1_nz;
  assign w_f2_ok     = w_f2_nz;
  assign w_dup_err   = 1'b0;
  assign w_alloc_err = 1'b0;
`endif

  assign w_push_n    = {1'b0, w_f1_ok} + {1'b0, w_f2_ok};
  assign w_cnt_after = r_count - cnt_t'(w_grant_n) + cnt_t'(w_push_n);
  assign w_overflow  = (w_cnt_after > cnt_t'(FREE_DEPTH));
  assign w_push_en   = (r_state == READY) && !w_overflow;
  assign w_cnt_next  = w_overflow ? (r_count - cnt_t'(w_grant_n)) : w_cnt_after;
  assign w_err_set   = w_req_illegal ||
                       ((r_state == INIT) && (w_f1_nz || w_f2_nz)) ||
                       ((r_state == READY) && w_overflow) ||
                       w_dup_err || w_alloc_err;

  always_comb begin
    w_state_nxt = r_state;
    w_wr_en_1   = 1'b0;
    w_wr_en_2   = 1'b0;
    w_wr_tag_1  = TAG_ZERO;
    w_wr_tag_2  = TAG_ZERO;
    w_tail_adv  = 2'd0;
    case (r_state)
      INIT: begin
        w_wr_en_1  = 1'b1;
        w_wr_tag_1 = w_init_tag;
        w_tail_adv = 2'd1;
        if (r_init_ptr == ptr_t'(FREE_DEPTH - 1)) w_state_nxt = READY;
      end
      READY: begin
        // A lone free_tag_2 is packed into the first write slot.
        if (w_push_en) begin
          w_wr_en_1  = w_f1_ok || w_f2_ok;
          w_wr_tag_1 = w_f1_ok ? free_tag_1 : free_tag_2;
          w_wr_en_2  = w_f1_ok && w_f2_ok;
          w_wr_tag_2 = free_tag_2;
          w_tail_adv = w_push_n;
        end
      end
      default: w_state_nxt = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= INIT;
      r_init_ptr <= '0;
      r_count    <= '0;
      r_error    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == INIT) begin
        r_init_ptr <= r_init_ptr + ptr_t'(1);
        if (r_init_ptr == ptr_t'(FREE_DEPTH - 1)) r_count <= cnt_t'(FREE_DEPTH);
      end else begin
        r_count <= w_cnt_next;
      end
      if (w_err_set) r_error <= 1'b1;
    end
  end

  tag_ring_buffer u_ring (
    .i_clk      (clk),
    .i_rst_n    (reset_n),
    .i_wr_en_1  (w_wr_en_1),
    .i_wr_tag_1 (w_wr_tag_1),
    .i_wr_en_2  (w_wr_en_2),
    .i_wr_tag_2 (w_wr_tag_2),
    .i_head_adv (w_grant_n),
    .i_tail_adv (w_tail_adv),
    .o_rd_tag_1 (w_rd_tag_1),
    .o_rd_tag_2 (w_rd_tag_2)
  );

  assign alloc_grant = w_grant;
  assign alloc_tag_1 = w_grant ? w_rd_tag_1 : TAG_ZERO;
  assign alloc_tag_2 = (w_grant && (w_req == 2'd2)) ? w_rd_tag_2 : TAG_ZERO;
  assign free_count  = reset_n ? r_count : '0;
  assign ready       = w_ready;
  assign error       = r_error;
  assign o_dbg_state = r_state;

endmodule
